// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-the-fly key rewinding.
// Optional KEY_CACHE_EN keeps the last key and its round-10 key to skip forward expansion.
module aes_dec_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipherText,
    input  logic [127:0] key,
    output logic         rdy,
    output logic         done,
    output logic [127:0] plainText
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, KEYEXP, INIT, DEC} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk;

`ifdef KEY_CACHE_EN
    logic         cache_valid;
    logic [127:0] cache_key;
    logic [127:0] cache_rk;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i = row + 4*column sits at bits [127-8i -: 8]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sw_in, sw_rot, sw_out, rc_word;
    logic [127:0] rk_fwd, rk_rew;
    logic [127:0] isr, isb, ark, round_out;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // The same four SubWord lanes serve expansion (on w3) and rewinding (on recovered w3)
    assign sw_in   = (fsm == KEYEXP) ? w3 : (w3 ^ w2);
    assign sw_rot  = {sw_in[23:0], sw_in[31:24]};
    assign rc_word = {rcon(cnt), 24'h000000};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            assign sw_out[31-8*g -: 8] = sbox(sw_rot[31-8*g -: 8]);
        end
        for (g = 0; g < 16; g++) begin : g_invsub
            assign isb[127-8*g -: 8] = inv_sbox(isr[127-8*g -: 8]);
        end
    endgenerate

    assign rk_fwd[127:96] = w0 ^ sw_out ^ rc_word;
    assign rk_fwd[95:64]  = w1 ^ rk_fwd[127:96];
    assign rk_fwd[63:32]  = w2 ^ rk_fwd[95:64];
    assign rk_fwd[31:0]   = w3 ^ rk_fwd[63:32];

    assign rk_rew = {w0 ^ sw_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    assign isr       = inv_shift_rows(st);
    assign ark       = isb ^ rk;
    assign round_out = (cnt == 4'd0) ? ark : inv_mix_columns(ark);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= 4'd0;
            st        <= '0;
            rk        <= '0;
            rdy       <= 1'b1;
            done      <= 1'b0;
            plainText <= '0;
`ifdef KEY_CACHE_EN
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st  <= cipherText;
                        rdy <= 1'b0;
`ifdef KEY_CACHE_EN
                        if (cache_valid && (key == cache_key)) begin
                            rk  <= cache_rk;
                            cnt <= LAST;
                            fsm <= INIT;
                        end else begin
                            rk          <= key;
                            cnt         <= 4'd1;
                            fsm         <= KEYEXP;
                            cache_valid <= 1'b0;
                            cache_key   <= key;
                        end
`else
                        rk  <= key;
                        cnt <= 4'd1;
                        fsm <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    rk <= rk_fwd;
                    if (cnt == LAST) begin
                        fsm <= INIT;
`ifdef KEY_CACHE_EN
                        cache_rk    <= rk_fwd;
                        cache_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                INIT: begin
                    st  <= st ^ rk;
                    rk  <= rk_rew;
                    cnt <= LAST - 4'd1;
                    fsm <= DEC;
                end
                DEC: begin
                    st <= round_out;
                    rk <= rk_rew;
                    if (cnt == 4'd0) begin
                        plainText <= round_out;
                        done      <= 1'b1;
                        rdy       <= 1'b1;
                        fsm       <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_core.sv
// Directed self-checking bench for aes_dec_core using FIPS-197 / textbook vectors.
// Define KEY_CACHE_EN for both files to also exercise the key-cache latency path.
module tb_aes_dec_core;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] cipherText;
    logic [127:0] key;
    logic         rdy;
    logic         done;
    logic [127:0] plainText;

    int checks;
    int errors;
    logic [127:0] lastPt;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CT_B  = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] PT_B  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KEY_C = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_C  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_dec_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipherText (cipherText),
        .key        (key),
        .rdy        (rdy),
        .done       (done),
        .plainText  (plainText)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] ct, input logic [127:0] k);
        start      = s;
        cipherText = ct;
        key        = k;
    endtask

    // Called at a negedge; the next posedge accepts the request
    task automatic runOp(input string tag, input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] expPt, input int latency, input bit scramble);
        applyStimulus(1'b1, ct, k);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_busy"}, {127'd0, rdy}, 128'd0);
        checkOutput({tag, "_pt_held"}, plainText, lastPt);
        for (int i = 1; i <= latency; i++) begin
            if (scramble)
                applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                              {$urandom, $urandom, $urandom, $urandom});
            else
                applyStimulus(1'b0, ct, k);
            @(posedge clk);
            @(negedge clk);
            if (i < latency) begin
                checkOutput({tag, "_done_low"}, {127'd0, done}, 128'd0);
            end else begin
                checkOutput({tag, "_done"}, {127'd0, done}, 128'd1);
                checkOutput({tag, "_pt"}, plainText, expPt);
                checkOutput({tag, "_rdy"}, {127'd0, rdy}, 128'd1);
            end
        end
        lastPt = expPt;
        start  = 1'b0;
    endtask

    task automatic afterDone(input string tag, input logic [127:0] expPt);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, {127'd0, done}, 128'd0);
        checkOutput({tag, "_pt_keep"}, plainText, expPt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lastPt = '0;
        rst    = 1'b1;
        applyStimulus(1'b1, CT_A, KEY_A);

        $display("[TB] reset with start held high");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_rdy", {127'd0, rdy}, 128'd1);
            checkOutput("rst_done", {127'd0, done}, 128'd0);
            checkOutput("rst_pt", plainText, 128'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_no_start", {127'd0, rdy}, 128'd1);

        $display("[TB] FIPS-197 C.1 vector");
        runOp("vecA", CT_A, KEY_A, PT_A, 21, 1'b0);
        afterDone("vecA", PT_A);

        $display("[TB] textbook vector");
        runOp("vecB", CT_B, KEY_B, PT_B, 21, 1'b0);
        afterDone("vecB", PT_B);

        $display("[TB] FIPS-197 B vector with noisy inputs while busy");
        runOp("vecC", CT_C, KEY_C, PT_C, 21, 1'b1);
        for (int i = 0; i < 3; i++) afterDone("vecC", PT_C);

        $display("[TB] reset in the middle of decryption");
        applyStimulus(1'b1, CT_A, KEY_A);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abort_done_low", {127'd0, done}, 128'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rdy", {127'd0, rdy}, 128'd1);
        checkOutput("abort_done", {127'd0, done}, 128'd0);
        checkOutput("abort_pt", plainText, 128'd0);
        rst    = 1'b0;
        lastPt = '0;
        runOp("retry", CT_A, KEY_A, PT_A, 21, 1'b0);
        afterDone("retry", PT_A);

`ifdef KEY_CACHE_EN
        $display("[TB] key cache back-to-back requests");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        lastPt = '0;
        runOp("cold", CT_A, KEY_A, PT_A, 21, 1'b0);
        runOp("hit", CT_A, KEY_A, PT_A, 11, 1'b0);
        runOp("miss", CT_C, KEY_C, PT_C, 21, 1'b0);
        afterDone("miss", PT_C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_dec_core.md
Name: aes_dec_core

Overview:
Iterative AES-128 decryption core (FIPS-197 inverse cipher), one round per clock. It is the receive-side counterpart of aesEncCore: it takes a 128-bit ciphertext and the same 128-bit cipher key, and returns the plaintext. The round-10 key is derived by forward expansion, then rewound one round per cycle during decryption. No round-key storage array is used.

Parameters:
NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only while rdy=1
cipherText  input  128  ciphertext; byte 0 = [127:120]; sampled when start accepted
key  input  128  cipher key, same byte order; sampled when start accepted
rdy  output  1  core idle, start will be accepted
done  output  1  one-cycle pulse, plainText valid
plainText  output  128  decrypted block, byte 0 = [127:120]

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: rdy=1, done=0, plainText=0, FSM=IDLE, round counter=0, internal state and key registers=0.
- FSM states: IDLE -> KEYEXP -> INIT -> DEC -> IDLE.
- IDLE:
  - rdy=1.
  - When start=1 at an edge: capture cipherText into the state register and key into the round-key register, set cnt=1, go to KEYEXP.
- KEYEXP (10 cycles, cnt 1..10):
  - rk <= forward expansion of rk using Rcon[cnt].
  - After cnt=10, rk holds round key 10; go to INIT.
- INIT (1 cycle):
  - state <= state ^ rk10.
  - rk <= rewind(rk10) = rk9.
  - Rewind rule: w[i-4] = w[i] ^ w[i-1] for the three upper words; w0 uses SubWord/RotWord/Rcon.
  - Go to DEC with r=9.
- DEC (10 cycles, r=9..0):
  - state <= InvShiftRows, then InvSubBytes, then AddRoundKey(rk_r), then InvMixColumns.
  - InvMixColumns is omitted when r=0.
  - rk <= rewind(rk_r); the Rcon index decrements each cycle.
  - After r=0: plainText <= result, done=1 for exactly one cycle, rdy=1, go to IDLE.
- Latency: done is high in the cycle after the 21st rising edge following the accepting edge (the edge that sampled start=1). No throughput overlap.
- plainText holds its value until the next done. It is not cleared at the next start.
- start while rdy=0 is ignored; no queueing.
- start in the same cycle that done=1: accepted, because rdy=1 in that cycle.
- cipherText and key are don't-care after the accepting edge; later changes do not affect the result in flight.
- Reset mid-operation: aborts the operation. The next cycle shows reset values; no done pulse is produced for the aborted block.
- S-box and inverse S-box:
  - Both are built from one shared GF(2^8) multiplicative-inverse function (polynomial 0x11B) plus the forward or inverse affine transform.
  - No 256-entry tables.
  - 16 InvSubBytes lanes plus 4 SubWord lanes for the key path.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.

Optional Feature:
KEY_CACHE_EN
- Defined: the core keeps the last accepted key and its derived rk10 plus a valid bit; valid is cleared by rst.
  - If start arrives with key equal to the cached key and valid=1: skip KEYEXP, go directly to INIT with the cached rk10. Latency becomes 11 edges.
  - Otherwise: normal path; the cache updates at the end of KEYEXP.
  - Reset mid-KEYEXP leaves the cache invalid.
- Undefined: no cache registers; latency is always 21.
- Functional results are identical in both builds.

Test Plan:
1. rst for 3 cycles with start=1 -> rdy=1, done=0, plainText=0 throughout; no operation starts.
2. key=000102030405060708090a0b0c0d0e0f, cipherText=69c4e0d86a7b0430d8cdb78070b4c55a, start pulsed -> after 21 edges done=1 for 1 cycle, plainText=00112233445566778899aabbccddeeff, rdy=0 during the operation.
3. key=0F1571C947D9E8590CB7ADD6AF7F6798, cipherText=ff0b844a0853bf7c6934ab4364148fb9 -> plainText=0123456789ABCDEFFEDCBA9876543210. Then feed that plaintext to aesEncCore -> cipherText round-trips.
4. key=2b7e151628aed2a6abf7158809cf4f3c, cipherText=3925841d02dc09fbdc118597196a0b32; toggle start and change the inputs every cycle while busy -> plainText=3243f6a8885a308d313198a2e0370734; exactly one done pulse.
5. Assert rst at DEC r=4, then immediately start vector 2 -> no done for the aborted op; correct result 21 edges later.
6. KEY_CACHE_EN: back-to-back vector 2 twice with start held high -> second done 11 edges after acceptance and correct. A different key on the third request -> 21 edges.
